// File: rtl/multi_channel_level_meter_if.sv
// Sample-in / LED-frame-out handshake bundle for the multi-channel level meter.
// master drives samples and frame-ready; slave is the meter core.
interface multi_channel_level_meter_if #(
   parameter int unsigned channel_count   = 2,
   parameter int unsigned sample_width    = 16,
   parameter int unsigned indicator_width = 32
);
   logic                                       i_valid;
   logic                                       i_ready;
   logic [2:0]                                 i_channel;
   logic [sample_width-1:0]                    i_value;
   logic                                       i_mode;
   logic                                       o_valid;
   logic                                       o_ready;
   logic [channel_count*indicator_width-1:0]   o_array;

   modport master (
      output i_valid, i_channel, i_value, i_mode, o_ready,
      input  i_ready, o_valid, o_array
   );

   modport slave (
      input  i_valid, i_channel, i_value, i_mode, o_ready,
      output i_ready, o_valid, o_array
   );
endinterface

// File: rtl/multi_channel_level_meter.sv
// N-channel audio level meter: per-section peak |x| per channel, LED level with
// peak-hold/decay, one LED frame for all channels per section.
module multi_channel_level_meter #(
   parameter int unsigned channel_count        = 2,
   parameter int unsigned sample_width         = 16,
   parameter int unsigned indicator_width      = 32,
   parameter int unsigned section_sample_count = 32,
   parameter int unsigned sample_rate          = 44100,
   parameter int unsigned peak_hold_time_ms    = 1000
) (
   input logic                        clk,
   input logic                        reset,
   multi_channel_level_meter_if.slave bus
);
   localparam int unsigned mag_width   = sample_width - 1;
   localparam int unsigned lvl_width   = $clog2(indicator_width + 1);
   localparam int unsigned level_shift = sample_width - 1 - $clog2(indicator_width);
   localparam int unsigned cnt_width   =
      (section_sample_count > 1) ? $clog2(section_sample_count) : 1;
   localparam int unsigned hold_frames =
      sample_rate * peak_hold_time_ms / (1000 * section_sample_count);
   localparam int unsigned hold_width  = (hold_frames > 0) ? $clog2(hold_frames + 1) : 1;

   localparam logic [cnt_width-1:0]       cnt_last  = cnt_width'(section_sample_count - 1);
   localparam logic [cnt_width-1:0]       cnt_one   = 1;
   localparam logic [hold_width-1:0]      hold_init = hold_width'(hold_frames);
   localparam logic [hold_width-1:0]      hold_one  = 1;
   localparam logic [lvl_width-1:0]       lvl_one   = 1;
   localparam logic [indicator_width-1:0] led_one   = 1;

   logic [mag_width-1:0]  max_q   [channel_count];
   logic [cnt_width-1:0]  cnt_q   [channel_count];
   logic [lvl_width-1:0]  lvl_q   [channel_count];
   logic [lvl_width-1:0]  peak_q  [channel_count];
   logic [lvl_width-1:0]  peak_d  [channel_count];
   logic [hold_width-1:0] hold_q  [channel_count];
   logic [hold_width-1:0] hold_d  [channel_count];
   logic [mag_width-1:0]  merged  [channel_count];
   logic [lvl_width-1:0]  lvl_new [channel_count];

   logic [channel_count-1:0]                 done_q;
   logic [channel_count-1:0]                 sel;
   logic signed [sample_width-1:0]           x;
   logic [mag_width-1:0]                     mag;
   logic                                     in_range;
   logic                                     accept;
   logic                                     commit;
   logic                                     o_valid_q;
   logic [channel_count*indicator_width-1:0] o_array_q;
   logic [channel_count*indicator_width-1:0] o_array_d;

   always_comb begin
      x        = bus.i_value;
      in_range = 32'(bus.i_channel) < channel_count;
      for (int unsigned c = 0; c < channel_count; c++) begin
         sel[c] = (32'(bus.i_channel) == c);
      end
      // Most-negative sample saturates instead of wrapping back to itself.
      if (x[sample_width-1]) begin
         mag = (x[mag_width-1:0] == '0) ? '1 : mag_width'(-x);
      end else begin
         mag = x[mag_width-1:0];
      end
      // Out-of-range channels are always accepted and dropped.
      bus.i_ready = !in_range || !(|(done_q & sel));
      accept      = bus.i_valid && bus.i_ready;
      commit      = (&done_q) && (!o_valid_q || bus.o_ready);
   end

   always_comb begin
      for (int unsigned c = 0; c < channel_count; c++) begin
         merged[c]  = (mag > max_q[c]) ? mag : max_q[c];
         lvl_new[c] = (merged[c] == '0) ? '0 : lvl_width'(merged[c] >> level_shift) + lvl_one;
      end
   end

   always_comb begin
      o_array_d = '0;
      for (int unsigned c = 0; c < channel_count; c++) begin
         logic [indicator_width-1:0] bar;
         logic [indicator_width-1:0] dot;
         logic [indicator_width-1:0] pk;
         peak_d[c] = peak_q[c];
         hold_d[c] = hold_q[c];
         if (lvl_q[c] >= peak_q[c]) begin
            peak_d[c] = lvl_q[c];
            hold_d[c] = hold_init;
         end else if (hold_q[c] != '0) begin
            hold_d[c] = hold_q[c] - hold_one;
         end else begin
            peak_d[c] = (peak_q[c] - lvl_one > lvl_q[c]) ? peak_q[c] - lvl_one : lvl_q[c];
         end
         // Shift past the top bit yields 0, so 0 - 1 gives a full bar at lvl == W.
         bar = (led_one << lvl_q[c]) - led_one;
         dot = (lvl_q[c] == '0) ? '0 : led_one << (lvl_q[c] - lvl_one);
         pk  = (peak_d[c] == '0) ? '0 : led_one << (peak_d[c] - lvl_one);
         o_array_d[c*indicator_width +: indicator_width] = (bus.i_mode ? dot : bar) | pk;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid_q <= 1'b0;
         o_array_q <= '0;
         done_q    <= '0;
         for (int unsigned c = 0; c < channel_count; c++) begin
            max_q[c]  <= '0;
            cnt_q[c]  <= '0;
            lvl_q[c]  <= '0;
            peak_q[c] <= '0;
            hold_q[c] <= '0;
         end
      end else begin
         if (commit) begin
            o_valid_q <= 1'b1;
            o_array_q <= o_array_d;
            done_q    <= '0;
            for (int unsigned c = 0; c < channel_count; c++) begin
               peak_q[c] <= peak_d[c];
               hold_q[c] <= hold_d[c];
            end
         end else if (bus.o_ready) begin
            o_valid_q <= 1'b0;
         end
         for (int unsigned c = 0; c < channel_count; c++) begin
            if (accept && sel[c]) begin
               if (cnt_q[c] == cnt_last) begin
                  max_q[c]  <= '0;
                  cnt_q[c]  <= '0;
                  lvl_q[c]  <= lvl_new[c];
                  done_q[c] <= 1'b1;
               end else begin
                  max_q[c] <= merged[c];
                  cnt_q[c] <= cnt_q[c] + cnt_one;
               end
            end
         end
      end
   end

   assign bus.o_valid = o_valid_q;
   assign bus.o_array = o_array_q;
endmodule

// File: tb/tb_multi_channel_level_meter.sv
// Bench for multi_channel_level_meter: vector table plus peak-hold, stall and
// mid-section reset sequences; frames checked against a queue of expected values.
module tb_multi_channel_level_meter;
   localparam int unsigned sec_len     = 32;
   localparam int unsigned hold_ms     = 4;
   localparam int          hold_frames = 44100 * hold_ms / (1000 * sec_len);

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multi_channel_level_meter_if #(
      .channel_count   (2),
      .sample_width    (16),
      .indicator_width (32)
   ) bus ();

   multi_channel_level_meter #(
      .channel_count        (2),
      .sample_width         (16),
      .indicator_width      (32),
      .section_sample_count (sec_len),
      .sample_rate          (44100),
      .peak_hold_time_ms    (hold_ms)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] v0;
      logic [15:0] v1;
      logic        mode;
      logic [63:0] exp_arr;
   } vec_t;

   vec_t        vecs [7];
   int          tests = 0;
   int          fails = 0;
   logic [63:0] exp_q [$];
   int          m_peak [2];
   int          m_hold [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   function automatic int lvl_of(input logic [15:0] v);
      int a;
      a = int'($signed(v));
      if (a < 0) a = -a;
      if (a > 32767) a = 32767;
      return (a == 0) ? 0 : a / 1024 + 1;
   endfunction

   function automatic logic [31:0] leds(input int lvl, input int peak, input logic mode);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if ((mode ? (i == lvl - 1) : (i < lvl)) || (i == peak - 1)) r[i] = 1'b1;
      end
      return r;
   endfunction

   task automatic model_frame(input logic [15:0] v0, input logic [15:0] v1, input logic mode,
                              output logic [63:0] e);
      int lv [2];
      lv[0] = lvl_of(v0);
      lv[1] = lvl_of(v1);
      for (int c = 0; c < 2; c++) begin
         if (lv[c] >= m_peak[c]) begin
            m_peak[c] = lv[c];
            m_hold[c] = hold_frames;
         end else if (m_hold[c] > 0) begin
            m_hold[c]--;
         end else begin
            m_peak[c] = (m_peak[c] - 1 > lv[c]) ? m_peak[c] - 1 : lv[c];
         end
         e[c*32 +: 32] = leds(lv[c], m_peak[c], mode);
      end
   endtask

   task automatic send(input int ch, input logic [15:0] v);
      int n;
      n             = 0;
      bus.i_valid   = 1'b1;
      bus.i_channel = 3'(ch);
      bus.i_value   = v;
      @(negedge clk);
      while (!bus.i_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: i_ready stayed 0 for ch %0d, want 1", ch);
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] v0, input logic [15:0] v1, input logic mode);
      bus.i_mode = mode;
      for (int s = 0; s < int'(sec_len); s++) begin
         send(0, v0);
         send(1, v1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [15:0] v0, input logic [15:0] v1, input logic mode);
      logic [63:0] e;
      model_frame(v0, v1, mode, e);
      exp_q.push_back(e);
      send_frame(v0, v1, mode);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("frames_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      bus.i_valid   = 1'b0;
      bus.i_channel = '0;
      reset         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         m_peak[c] = 0;
         m_hold[c] = 0;
      end
      @(negedge clk);
      check("reset_o_valid", 64'(bus.o_valid), 64'd0);
      check("reset_o_array", bus.o_array, 64'd0);
      check("reset_i_ready", 64'(bus.i_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted frame must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.o_valid && bus.o_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got %h, want no frame", bus.o_array);
         end else begin
            check("frame", bus.o_array, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, want run to complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.i_valid   = 1'b0;
      bus.i_channel = '0;
      bus.i_value   = '0;
      bus.i_mode    = 1'b0;
      bus.o_ready   = 1'b1;

      vecs[0] = '{16'h7FFF, 16'h0400, 1'b0, 64'h0000_0003_FFFF_FFFF};
      vecs[1] = '{16'h8000, 16'h8000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[2] = '{16'h2000, 16'h0000, 1'b1, 64'h0000_0000_0000_0100};
      vecs[3] = '{16'hFC00, 16'h0001, 1'b0, 64'h0000_0001_0000_0003};
      vecs[4] = '{16'h03FF, 16'h0000, 1'b0, 64'h0000_0000_0000_0001};
      vecs[5] = '{16'h4000, 16'hC000, 1'b1, 64'h0001_0000_0001_0000};
      vecs[6] = '{16'h8001, 16'h0000, 1'b1, 64'h0000_0000_8000_0000};

      for (int i = 0; i < 7; i++) begin
         do_reset();
         exp_q.push_back(vecs[i].exp_arr);
         send_frame(vecs[i].v0, vecs[i].v1, vecs[i].mode);
         check("latency_o_valid", 64'(bus.o_valid), 64'd1);
         wait_drain();
      end

      // Full scale, dot-mode frame under held peak, then silence: hold then decay.
      do_reset();
      run_frame(16'h7FFF, 16'h7FFF, 1'b0);
      run_frame(16'h2000, 16'h0000, 1'b1);
      for (int k = 0; k < 40; k++) run_frame(16'h0000, 16'h0000, 1'b0);
      wait_drain();

      // Output held across two sections.
      do_reset();
      bus.o_ready = 1'b0;
      run_frame(16'h7FFF, 16'h0400, 1'b0);
      run_frame(16'h0400, 16'h7FFF, 1'b0);
      bus.i_valid   = 1'b1;
      bus.i_value   = 16'h7FFF;
      bus.i_channel = 3'd0;
      repeat (4) begin
         @(negedge clk);
         check("stall_i_ready_ch0", 64'(bus.i_ready), 64'd0);
         check("stall_o_valid", 64'(bus.o_valid), 64'd1);
         check("stall_o_array", bus.o_array, 64'h0000_0003_FFFF_FFFF);
      end
      bus.i_channel = 3'd1;
      @(negedge clk);
      check("stall_i_ready_ch1", 64'(bus.i_ready), 64'd0);
      bus.i_channel = 3'd5;
      @(negedge clk);
      check("stall_i_ready_ch5", 64'(bus.i_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.o_ready = 1'b1;
      wait_drain();

      // Out-of-range channel ignored; reset mid-section discards partial data.
      do_reset();
      for (int s = 0; s < 10; s++) begin
         send(0, 16'h7FFF);
         send(5, 16'h7FFF);
         send(1, 16'h7FFF);
      end
      do_reset();
      for (int s = 0; s < int'(sec_len) - 1; s++) begin
         send(0, 16'h0400);
         send(5, 16'h7FFF);
         send(1, 16'h0400);
      end
      repeat (3) @(posedge clk);
      #1;
      check("partial_no_o_valid", 64'(bus.o_valid), 64'd0);
      exp_q.push_back(64'h0000_0003_0000_0003);
      send(0, 16'h0400);
      send(1, 16'h0400);
      @(posedge clk);
      #1;
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
